// File: rtl/mesh_pkg.sv
// rtl/mesh_pkg.sv - mesh packet header layout and destination legality check
package mesh_pkg;

  localparam int NXT_JMP_W = 8;
  localparam int ROW_W     = 4;
  localparam int COL_W     = 4;
  localparam int MODE_W    = 1;
  localparam int HDR_W     = NXT_JMP_W + ROW_W + COL_W + MODE_W;

  typedef struct packed {
    logic [NXT_JMP_W-1:0] nxt_jmp;
    logic [ROW_W-1:0]     row;
    logic [COL_W-1:0]     col;
    logic [MODE_W-1:0]    mode;
  } mesh_hdr_t;

  // Terminals sit on the ring around the mesh, hence the +1 on each bound.
  function automatic logic is_legal_dest(input logic [ROW_W-1:0] row,
                                         input logic [COL_W-1:0] col,
                                         input int rows, input int colums,
                                         input logic [ROW_W+COL_W-1:0] bdcst);
    return ({row, col} == bdcst) ||
           ((int'(row) <= rows + 1) && (int'(col) <= colums + 1));
  endfunction

endpackage

// File: rtl/mesh_term_src_if.sv
// rtl/mesh_term_src_if.sv - host push / router pop handshake bundle for a terminal source
interface mesh_term_src_if #(parameter int pckg_sz = 32);
  logic               push;
  logic [pckg_sz-1:0] data_in;
  logic               full;
  logic               pndng_i_in;
  logic [pckg_sz-1:0] data_out_i_in;
  logic               popin;

  modport master (output push, data_in, popin,
                  input  full, pndng_i_in, data_out_i_in);
  modport slave  (input  push, data_in, popin,
                  output full, pndng_i_in, data_out_i_in);
endinterface

// File: rtl/mesh_src_fifo.sv
// rtl/mesh_src_fifo.sv - generic first-word-fall-through FIFO, any depth >= 2
module mesh_src_fifo #(
  parameter int width = 32,
  parameter int depth = 4,
  localparam int CW   = $clog2(depth + 1),
  localparam int PW   = $clog2(depth)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [width-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [width-1:0] dout
);

  localparam logic [CW-1:0] DEPTH_C = CW'(depth);
  localparam logic [PW-1:0] LAST_P  = PW'(depth - 1);

  logic [width-1:0] mem [depth];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic             do_pop, do_push;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && !empty;
  // A pop frees the slot a full-FIFO push lands in.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_P) ? '0 : rd_ptr + 1'b1;
      if (do_push) wr_ptr <= (wr_ptr == LAST_P) ? '0 : wr_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mesh_term_src.sv
// rtl/mesh_term_src.sv - terminal source stage: dest screening, FWFT buffer, sticky flags; stats under MESH_SRC_STATS_EN
module mesh_term_src
  import mesh_pkg::*;
#(
  parameter int rows       = 4,
  parameter int colums     = 4,
  parameter int pckg_sz    = 32,
  parameter int fifo_depth = 4,
  parameter logic [ROW_W+COL_W-1:0] bdcst = {8{1'b1}}
) (
  input  logic                            clk,
  input  logic                            reset,
  mesh_term_src_if.slave                  bus,
  output logic [$clog2(fifo_depth+1)-1:0] count,
  output logic                            overflow,
  output logic                            bad_dest
`ifdef MESH_SRC_STATS_EN
  ,
  output logic [31:0]                     acc_cnt,
  output logic [31:0]                     drop_cnt,
  output logic [31:0]                     rej_cnt
`endif
);

  localparam int ROW_MSB = pckg_sz - 1 - NXT_JMP_W;
  localparam int COL_MSB = ROW_MSB - ROW_W;

  logic legal, empty, take, drop, rej;

  assign legal = is_legal_dest(bus.data_in[ROW_MSB -: ROW_W], bus.data_in[COL_MSB -: COL_W],
                               rows, colums, bdcst);
  assign rej   = bus.push && !legal;
  assign drop  = bus.push && legal && bus.full && !bus.popin;
  assign take  = bus.push && legal && !drop;

  mesh_src_fifo #(.width(pckg_sz), .depth(fifo_depth)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (bus.push && legal),
    .din   (bus.data_in),
    .pop   (bus.popin),
    .full  (bus.full),
    .empty (empty),
    .count (count),
    .dout  (bus.data_out_i_in)
  );

  assign bus.pndng_i_in = !empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      bad_dest <= 1'b0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (rej)  bad_dest <= 1'b1;
    end
  end

`ifdef MESH_SRC_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_cnt  <= '0;
      drop_cnt <= '0;
      rej_cnt  <= '0;
    end else begin
      if (take && acc_cnt  != '1) acc_cnt  <= acc_cnt + 1'b1;
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      if (rej  && rej_cnt  != '1) rej_cnt  <= rej_cnt + 1'b1;
    end
  end
`endif

endmodule
